// File: rtl/ps2_scan_fifo.sv
// PS/2 scancode buffer: level done/ack capture from the receiver into a FIFO,
// read by the Z80 through data/status ports, with an optional level interrupt.
module ps2_scan_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic       clk,
  input  logic       n_res,
  input  logic       ps2_done,
  input  logic [7:0] ps2_out,
  output logic       ps2_ack,
  input  logic       rd_data,
  input  logic       rd_stat,
  input  logic       wr_ctrl,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       irq
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] HALF_CNT = (AW+1)'(DEPTH / 2);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } hs_state_e;

  hs_state_e state_q, state_d;
  logic      capture;

  logic [7:0]  mem [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          irq_en_q, irq_en_d;
  logic          irq_q;

  logic empty, full, flush, pop, push, ovf_set;
  logic [7:0] status;

  // One capture per done pulse: ACK is held until the receiver drops done.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ps2_done) begin
          capture = 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (!ps2_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_res) begin
    if (!n_res) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  assign ps2_ack = (state_q == S_ACK);

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign flush = wr_ctrl & din[0];
  // Status read takes priority over a data read when both strobes are high.
  assign pop     = rd_data & ~rd_stat & ~empty & ~flush;
  assign push    = capture & ~flush & (~full | pop);
  assign ovf_set = capture & ~flush & full & ~pop;

  always_comb begin
    wp_d     = wp_q;
    rp_d     = rp_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    irq_en_d = irq_en_q;
    if (pop)  rp_d = rp_q + AW'(1);
    if (push) wp_d = wp_q + AW'(1);
    if (push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (pop && !push) count_d = count_q - (AW+1)'(1);
    if (ovf_set)      ovf_d = 1'b1;
    else if (rd_stat) ovf_d = 1'b0;
    if (wr_ctrl) irq_en_d = din[7];
    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_res) begin
    if (!n_res) begin
      wp_q     <= '0;
      rp_q     <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_en_q & ~empty;
    end
  end

  // Storage is not reset; only entries behind valid pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) mem[wp_q] <= ps2_out;
  end

  assign status = {irq_en_q, 2'b00, (count_q >= HALF_CNT), full, ovf_q, 1'b0, ~empty};

  always_comb begin
    dout = 8'h00;
    if (rd_stat)                dout = status;
    else if (rd_data && !empty) dout = mem[rp_q];
  end

  assign irq = irq_q;

endmodule
